// File: rtl/mem_port_arbiter.sv
// Arbitrates the single 32-bit memory data port between a scalar path and a multi-beat vector path.
// Define ARB_SCALAR_PRIO_EN for fixed scalar priority; the default build uses round-robin on ties.
module mem_port_arbiter #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned LANES    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_req,
  input  logic                  s_we,
  input  logic [31:0]           s_addr,
  input  logic [31:0]           s_wdata,
  output logic                  s_gnt,
  output logic                  s_rvalid,
  output logic [31:0]           s_rdata,
  input  logic                  v_req,
  input  logic                  v_we,
  input  logic [31:0]           v_addr,
  input  logic [32*LANES-1:0]   v_wdata,
  output logic                  v_gnt,
  output logic                  v_done,
  output logic [32*LANES-1:0]   v_rdata,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CntW  = $clog2(LANES + READ_LAT + 1);
  localparam int unsigned VecW  = 32 * LANES;

  typedef enum logic [2:0] {StIdle, StScalar, StVBeat, StVDrain, StVDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     beat_q, beat_d;
  logic [31:0]         s_addr_q, s_addr_d;
  logic [31:0]         s_wdata_q, s_wdata_d;
  logic                s_we_q, s_we_d;
  logic [29:0]         v_base_q, v_base_d;
  logic                v_we_q, v_we_d;
  logic [VecW-1:0]     v_wdata_q, v_wdata_d;
  logic [READ_LAT-1:0] s_pipe_q, s_pipe_d;
  logic [READ_LAT-1:0] v_pipe_q, v_pipe_d;
  logic [LaneW-1:0]    lane_pipe_q [READ_LAT];
  logic [LaneW-1:0]    lane_pipe_d [READ_LAT];
  logic [VecW-1:0]     v_buf_q, v_buf_d;
  logic [VecW-1:0]     v_rdata_q, v_rdata_d;

  logic             grant_s, grant_v;
  logic             s_issue, v_issue;
  logic [LaneW-1:0] lane, cap_lane;
  logic             cap_v;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^v_addr[1:0];

`ifndef ARB_SCALAR_PRIO_EN
  // 1: vector won the last grant, so scalar wins the next tie.
  logic last_vec_q, last_vec_d;
`endif

  always_comb begin
    grant_s = 1'b0;
    grant_v = 1'b0;
    if (state_q == StIdle) begin
`ifdef ARB_SCALAR_PRIO_EN
      grant_s = s_req;
`else
      grant_s = s_req && (!v_req || last_vec_q);
`endif
      grant_v = v_req && !grant_s;
    end
  end

`ifndef ARB_SCALAR_PRIO_EN
  always_comb begin
    last_vec_d = last_vec_q;
    if (grant_v) begin
      last_vec_d = 1'b1;
    end else if (grant_s) begin
      last_vec_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_vec_q <= 1'b1;
    end else begin
      last_vec_q <= last_vec_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_we_d    = s_we_q;
    v_base_d  = v_base_q;
    v_we_d    = v_we_q;
    v_wdata_d = v_wdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_s) begin
          state_d   = StScalar;
          s_addr_d  = s_addr;
          s_wdata_d = s_wdata;
          s_we_d    = s_we;
        end else if (grant_v) begin
          state_d   = StVBeat;
          beat_d    = '0;
          v_base_d  = v_addr[31:2];
          v_we_d    = v_we;
          v_wdata_d = v_wdata;
        end
      end
      StScalar: state_d = StIdle;
      StVBeat: begin
        if (beat_q == CntW'(LANES - 1)) begin
          beat_d  = '0;
          state_d = v_we_q ? StVDone : StVDrain;
        end else begin
          beat_d = beat_q + CntW'(1);
        end
      end
      StVDrain: begin
        if (beat_q == CntW'(READ_LAT - 1)) begin
          beat_d  = '0;
          state_d = StVDone;
        end else begin
          beat_d = beat_q + CntW'(1);
        end
      end
      StVDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read-return tracking: one stage per cycle of memory latency.
  assign s_issue = (state_q == StScalar) && !s_we_q;
  assign v_issue = (state_q == StVBeat) && !v_we_q;
  assign lane    = beat_q[LaneW-1:0];

  always_comb begin
    s_pipe_d       = s_pipe_q;
    v_pipe_d       = v_pipe_q;
    lane_pipe_d    = lane_pipe_q;
    s_pipe_d[0]    = s_issue;
    v_pipe_d[0]    = v_issue;
    lane_pipe_d[0] = lane;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      s_pipe_d[i]    = s_pipe_q[i-1];
      v_pipe_d[i]    = v_pipe_q[i-1];
      lane_pipe_d[i] = lane_pipe_q[i-1];
    end
  end

  assign cap_v    = v_pipe_q[READ_LAT-1];
  assign cap_lane = lane_pipe_q[READ_LAT-1];

  // Lanes gather in v_buf; v_rdata changes only when the final lane lands.
  always_comb begin
    v_buf_d   = v_buf_q;
    v_rdata_d = v_rdata_q;
    if (cap_v) begin
      v_buf_d[32*cap_lane +: 32] = mem_rdata;
      if (cap_lane == LaneW'(LANES - 1)) begin
        v_rdata_d = v_buf_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      s_we_q      <= 1'b0;
      v_base_q    <= '0;
      v_we_q      <= 1'b0;
      v_wdata_q   <= '0;
      s_pipe_q    <= '0;
      v_pipe_q    <= '0;
      lane_pipe_q <= '{default: '0};
      v_buf_q     <= '0;
      v_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      s_we_q      <= s_we_d;
      v_base_q    <= v_base_d;
      v_we_q      <= v_we_d;
      v_wdata_q   <= v_wdata_d;
      s_pipe_q    <= s_pipe_d;
      v_pipe_q    <= v_pipe_d;
      lane_pipe_q <= lane_pipe_d;
      v_buf_q     <= v_buf_d;
      v_rdata_q   <= v_rdata_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (state_q == StScalar) begin
      mem_addr  = s_addr_q;
      mem_wdata = s_wdata_q;
      mem_we    = s_we_q;
    end else if (state_q == StVBeat) begin
      mem_addr  = {v_base_q, 2'b00} + 32'({beat_q, 2'b00});
      mem_wdata = v_wdata_q[32*lane +: 32];
      mem_we    = v_we_q;
    end
  end

  assign s_gnt    = (state_q == StScalar);
  assign v_gnt    = (state_q == StVBeat) && (beat_q == '0);
  assign v_done   = (state_q == StVDone);
  assign s_rvalid = s_pipe_q[READ_LAT-1];
  assign s_rdata  = s_rvalid ? mem_rdata : 32'h0;
  assign v_rdata  = v_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-1 memory model and expectation queues.
module tb_mem_port_arbiter;
  localparam int unsigned ReadLat = 1;
  localparam int unsigned Lanes   = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        we;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_req = 1'b0, s_we = 1'b0;
  logic [31:0]   s_addr = '0, s_wdata = '0;
  logic          s_gnt, s_rvalid;
  logic [31:0]   s_rdata;
  logic          v_req = 1'b0, v_we = 1'b0;
  logic [31:0]   v_addr = '0;
  logic [127:0]  v_wdata = '0;
  logic          v_gnt, v_done;
  logic [127:0]  v_rdata;
  logic [31:0]   mem_addr, mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [256];
  int            n_cmp = 0;
  int            n_fail = 0;
  beat_t         exp_beats[$];
  logic [31:0]   exp_rd[$];
  logic [127:0]  exp_vec[$];
  logic [7:0]    exp_gnt[$];
  logic [127:0]  prev_vrd = '0;
  logic [127:0]  vec_a = 128'h44444444_33333333_22222222_11111111;
  logic [127:0]  vec_w = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem[mem_addr[9:2]];
  end

  mem_port_arbiter #(
    .READ_LAT(ReadLat),
    .LANES   (Lanes)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_req    (s_req),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .v_req    (v_req),
    .v_we     (v_we),
    .v_addr   (v_addr),
    .v_wdata  (v_wdata),
    .v_gnt    (v_gnt),
    .v_done   (v_done),
    .v_rdata  (v_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s_gnt, s_rvalid, v_gnt, v_done, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {s_gnt, s_rvalid, v_gnt, v_done, mem_we});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, s_rdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h want 0", {mem_addr, mem_wdata, s_rdata});
    end
    n_cmp++;
    if (v_rdata !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_vrdata: got %h want 0", v_rdata);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({s_gnt, v_gnt, v_done, mem_we, mem_addr} !== 36'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h want 0", {s_gnt, v_gnt, v_done, mem_we, mem_addr});
    end
  endtask

  task automatic test_scalar();
    beat_t b;
    logic [31:0] r;
    @(negedge clk);
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h40; s_wdata = 32'hDEADBEEF;
    exp_beats.push_back('{addr: 32'h40, data: 32'hDEADBEEF, we: 1'b1});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_cmp++;
      if (s_gnt !== (k == 1 || k == 3)) begin
        n_fail++;
        $display("FAIL scalar_gnt c%0d: got %b want %b", k, s_gnt, (k == 1 || k == 3));
      end
      n_cmp++;
      if (mem_we !== (k == 1)) begin
        n_fail++;
        $display("FAIL scalar_we c%0d: got %b want %b", k, mem_we, (k == 1));
      end
      n_cmp++;
      if (s_rvalid !== (k == 4)) begin
        n_fail++;
        $display("FAIL scalar_rvalid c%0d: got %b want %b", k, s_rvalid, (k == 4));
      end
      if (s_gnt && exp_beats.size() > 0) begin
        b = exp_beats.pop_front();
        n_cmp++;
        if ({mem_addr, mem_wdata, mem_we} !== b) begin
          n_fail++;
          $display("FAIL scalar_beat c%0d: got %h want %h", k, {mem_addr, mem_wdata, mem_we}, b);
        end
      end
      if (s_rvalid && exp_rd.size() > 0) begin
        r = exp_rd.pop_front();
        n_cmp++;
        if (s_rdata !== r) begin
          n_fail++;
          $display("FAIL scalar_rdata c%0d: got %h want %h", k, s_rdata, r);
        end
      end
      if (s_gnt) s_req = 1'b0;
      if (k == 2) begin
        s_req = 1'b1; s_we = 1'b0; s_addr = 32'h40; s_wdata = 32'h0;
        exp_beats.push_back('{addr: 32'h40, data: 32'h0, we: 1'b0});
        exp_rd.push_back(32'hDEADBEEF);
      end
    end
    s_req = 1'b0;
    n_cmp++;
    if (exp_beats.size() + exp_rd.size() != 0) begin
      n_fail++;
      $display("FAIL scalar_leftover: got %0d want 0", exp_beats.size() + exp_rd.size());
    end
  endtask

  task automatic test_vector_write(input logic [31:0] addr, input logic [31:0] base,
                                   input logic [127:0] data);
    beat_t b;
    @(negedge clk);
    v_req = 1'b1; v_we = 1'b1; v_addr = addr; v_wdata = data;
    for (int i = 0; i < 4; i++)
      exp_beats.push_back('{addr: base + 32'(4 * i), data: data[32*i +: 32], we: 1'b1});
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (v_gnt !== (k == 1)) begin
        n_fail++;
        $display("FAIL vwr_gnt c%0d: got %b want %b", k, v_gnt, (k == 1));
      end
      n_cmp++;
      if (v_done !== (k == 5)) begin
        n_fail++;
        $display("FAIL vwr_done c%0d: got %b want %b", k, v_done, (k == 5));
      end
      n_cmp++;
      if (k <= 4) begin
        if (exp_beats.size() == 0) begin
          n_fail++;
          $display("FAIL vwr_beat c%0d: got beat want none", k);
        end else begin
          b = exp_beats.pop_front();
          if ({mem_addr, mem_wdata, mem_we} !== b) begin
            n_fail++;
            $display("FAIL vwr_beat c%0d: got %h want %h", k, {mem_addr, mem_wdata, mem_we}, b);
          end
        end
      end else if ({mem_addr, mem_wdata, mem_we} !== 65'h0) begin
        n_fail++;
        $display("FAIL vwr_idle c%0d: got %h want 0", k, {mem_addr, mem_wdata, mem_we});
      end
      if (v_gnt) v_req = 1'b0;
    end
  endtask

  task automatic test_vector_read(input logic [31:0] addr, input logic [127:0] expv);
    logic [127:0] e;
    @(negedge clk);
    v_req = 1'b1; v_we = 1'b0; v_addr = addr; v_wdata = '0;
    exp_vec.push_back(expv);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if (v_gnt !== (k == 1)) begin
        n_fail++;
        $display("FAIL vrd_gnt c%0d: got %b want %b", k, v_gnt, (k == 1));
      end
      n_cmp++;
      if (v_done !== (k == 6)) begin
        n_fail++;
        $display("FAIL vrd_done c%0d: got %b want %b", k, v_done, (k == 6));
      end
      if (k <= 4) begin
        n_cmp++;
        if ({mem_addr, mem_we} !== {addr + 32'(4 * (k - 1)), 1'b0}) begin
          n_fail++;
          $display("FAIL vrd_addr c%0d: got %h want %h", k, mem_addr, addr + 32'(4 * (k - 1)));
        end
      end
      if (k == 5) begin
        n_cmp++;
        if (v_rdata !== prev_vrd) begin
          n_fail++;
          $display("FAIL vrd_hold c%0d: got %h want %h", k, v_rdata, prev_vrd);
        end
      end
      if (v_done && exp_vec.size() > 0) begin
        e = exp_vec.pop_front();
        prev_vrd = e;
        n_cmp++;
        if (v_rdata !== e) begin
          n_fail++;
          $display("FAIL vrd_data c%0d: got %h want %h", k, v_rdata, e);
        end
      end
      if (v_gnt) v_req = 1'b0;
    end
    n_cmp++;
    if (exp_vec.size() != 0 || v_rdata !== prev_vrd) begin
      n_fail++;
      $display("FAIL vrd_final: got %h want %h", v_rdata, prev_vrd);
    end
  endtask

  task automatic test_wrap();
    test_vector_write(32'hFFFFFFF8, 32'hFFFFFFF8, vec_w);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    v_req = 1'b1; v_we = 1'b0; v_addr = 32'h100;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (v_gnt) v_req = 1'b0;
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({s_gnt, s_rvalid, v_gnt, v_done, mem_we, mem_addr, mem_wdata} !== 69'h0) begin
      n_fail++;
      $display("FAIL midreset_out: got %h want 0",
               {s_gnt, s_rvalid, v_gnt, v_done, mem_we, mem_addr, mem_wdata});
    end
    n_cmp++;
    if (v_rdata !== 128'h0) begin
      n_fail++;
      $display("FAIL midreset_vrdata: got %h want 0", v_rdata);
    end
    prev_vrd = '0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({v_done, v_gnt, mem_we, v_rdata} !== 131'h0) begin
        n_fail++;
        $display("FAIL midreset_quiet c%0d: got %h want 0", k, {v_done, v_gnt, mem_we, v_rdata});
      end
    end
    test_vector_read(32'h100, vec_a);
  endtask

  task automatic test_contention();
    int got;
    logic [7:0] g, e;
    got = 0;
    reset = 1'b0;
    s_req = 1'b1; s_we = 1'b1; s_addr = 32'h80; s_wdata = 32'h12345678;
    v_req = 1'b1; v_we = 1'b1; v_addr = 32'h200; v_wdata = vec_w;
`ifdef ARB_SCALAR_PRIO_EN
    for (int i = 0; i < 4; i++) exp_gnt.push_back("S");
`else
    for (int i = 0; i < 2; i++) begin
      exp_gnt.push_back("S");
      exp_gnt.push_back("V");
    end
`endif
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if ($countones({s_gnt, v_gnt, v_done}) > 1) begin
        n_fail++;
        $display("FAIL cont_overlap c%0d: got %b want one-hot", k, {s_gnt, v_gnt, v_done});
      end
      if (s_gnt || v_gnt) begin
        g = s_gnt ? "S" : "V";
        e = exp_gnt.pop_front();
        got++;
        n_cmp++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL cont_order #%0d: got %c want %c", got, g, e);
        end
      end
    end
    n_cmp++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL cont_count: got %0d want 4", got);
    end
    s_req = 1'b0;
    v_req = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_scalar();
    test_vector_write(32'h103, 32'h100, vec_a);
    test_vector_read(32'h100, vec_a);
    test_wrap();
    test_reset_mid();
    test_contention();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
